mem_port_arbiter: RTL

//   Shares the single-port 64x16 instruction/data memory between the multicycle CPU
//   (fetch/load/store via IorD mux) and a debug/loader port. Fixed CPU priority with
//   an anti-starvation counter for the debug port. Per-port req/gnt handshake and

---
 rtl/mem_port_arbiter.sv | 59 +++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read memory between the CPU and a debug port,
// CPU priority with a consecutive-denial counter that forces a debug win.
module mem_port_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rd,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wd,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rd,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          starve
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
    owner_t        resp_owner;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] cpu_last, dbg_last;
    assign starve     = wait_cnt == CW'(MAX_WAIT);
    // grants are masked while reset is held so nothing reaches the memory
    assign cpu_gnt    = reset && cpu_req && !(starve && dbg_req);
    assign dbg_gnt    = reset && dbg_req && !cpu_gnt;
    assign mem_addr   = dbg_gnt ? dbg_addr : cpu_addr;
    assign mem_wd     = dbg_gnt ? dbg_wd : cpu_wd;
    assign mem_we     = dbg_gnt ? dbg_we : cpu_gnt && cpu_we;
    assign cpu_rvalid = resp_owner == CPU;
    assign dbg_rvalid = resp_owner == DBG;
    assign cpu_rd     = cpu_rvalid ? mem_rd : cpu_last;
    assign dbg_rd     = dbg_rvalid ? mem_rd : dbg_last;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_owner <= NONE;
            wait_cnt   <= '0;
            cpu_last   <= '0;
            dbg_last   <= '0;
        end else begin
            resp_owner <= (cpu_gnt && !cpu_we) ? CPU : (dbg_gnt && !dbg_we) ? DBG : NONE;
            wait_cnt   <= (!dbg_req || dbg_gnt) ? '0 : starve ? wait_cnt : wait_cnt + CW'(1);
            if (cpu_rvalid) cpu_last <= mem_rd;
            if (dbg_rvalid) dbg_last <= mem_rd;
        end
    end
endmodule
